// File: rtl/ulaplus_pkg.sv
// Shared constants and encodings for the ULAplus palette controller.
package ulaplus_pkg;

  localparam logic [15:0] PORT_REG = 16'hbf3b;
  localparam logic [15:0] PORT_DAT = 16'hff3b;

  typedef enum logic [1:0] {
    GRP_PAL  = 2'b00,
    GRP_MODE = 2'b01,
    GRP_RSV2 = 2'b10,
    GRP_RSV3 = 2'b11
  } group_e;

  localparam int MODE_ACTIVE  = 0;
  localparam int MODE_GRAY    = 1;
  localparam int MODE_AUTOINC = 2;

  // Which value d_out presents, chosen when a read is first seen.
  typedef enum logic [1:0] {
    SRC_ADDR = 2'b00,
    SRC_MODE = 2'b01,
    SRC_PAL  = 2'b10,
    SRC_ZERO = 2'b11
  } rd_src_e;

  typedef enum logic [1:0] {
    PH_PAPER  = 2'b00,
    PH_INK    = 2'b01,
    PH_CPU    = 2'b10,
    PH_RDBACK = 2'b11
  } phase_e;

endpackage

// File: rtl/palette_unit_ram.sv
// Single-port synchronous palette RAM; q always shows the pre-write contents of mem[a].
module palette_ram #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk28,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk28) begin
    if (we) mem[a] <= d;
    q <= mem[a];
  end

endmodule

// File: rtl/palette_unit.sv
// ULAplus palette controller: CPU port decode, mode/address registers and a
// palette RAM time-shared between paper, ink and CPU on a 4-phase rotation.
module palette_unit
  import ulaplus_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int ENTRY_W = 8
) (
  input  logic               clk28,
  input  logic               rst_n,
  input  logic               en,
  input  logic               ioreq,
  input  logic               rd,
  input  logic               wr,
  input  logic [15:0]        a_reg,
  input  logic [7:0]         d_reg,
  output logic [7:0]         d_out,
  output logic               d_out_active,
  output logic               active,
  output logic               grayscale,
  input  logic [ADDR_W-1:0]  ink_addr,
  input  logic [ADDR_W-1:0]  paper_addr,
  output logic [ENTRY_W-1:0] ink,
  output logic [ENTRY_W-1:0] paper
);

  logic reg_cs, dat_cs;
  logic reg_wr_q, reg_rd_q, dat_wr_q, dat_rd_q;
  logic reg_wr_go, reg_rd_go, dat_wr_go, dat_rd_go, pal_wr_go, pal_rd_go;

  logic [7:0]         addr_reg, addr_inc;
  logic [2:0]         mode;
  group_e             grp;
  logic [ADDR_W-1:0]  addr_idx, wr_idx, rd_idx, ram_a;
  logic [ENTRY_W-1:0] wr_dat, rd_data, ram_q;
  logic               wr_pend, rd_pend, rd_issued, ram_we, cpu_rd;
  phase_e             phase;
  rd_src_e            rd_src;

  assign reg_cs = en && ioreq && (a_reg == PORT_REG);
  assign dat_cs = en && ioreq && (a_reg == PORT_DAT);

  // Each access acts once, in the first cycle its strobe is seen on the port.
  assign reg_wr_go = reg_cs && wr && !reg_wr_q;
  assign reg_rd_go = reg_cs && rd && !reg_rd_q;
  assign dat_wr_go = dat_cs && wr && !dat_wr_q;
  assign dat_rd_go = dat_cs && rd && !dat_rd_q;

  assign grp       = group_e'(addr_reg[7:6]);
  assign addr_idx  = addr_reg[ADDR_W-1:0];
  assign addr_inc  = {addr_reg[7:ADDR_W], addr_idx + ADDR_W'(1)};
  assign pal_wr_go = dat_wr_go && (grp == GRP_PAL);
  assign pal_rd_go = dat_rd_go && (grp == GRP_PAL);

  assign active    = mode[MODE_ACTIVE];
  assign grayscale = mode[MODE_GRAY];

  // The CPU slot gives a pending write priority; a pending read waits a rotation.
  always_comb begin
    ram_a  = paper_addr;
    ram_we = 1'b0;
    cpu_rd = 1'b0;
    case (phase)
      PH_INK: ram_a = ink_addr;
      PH_CPU: begin
        if (wr_pend) begin
          ram_a  = wr_idx;
          ram_we = 1'b1;
        end else if (rd_pend) begin
          ram_a  = rd_idx;
          cpu_rd = 1'b1;
        end
      end
      default: ram_a = paper_addr;
    endcase
  end

  palette_ram #(.AW(ADDR_W), .DW(ENTRY_W)) u_ram (
    .clk28 (clk28),
    .we    (ram_we),
    .a     (ram_a),
    .d     (wr_dat),
    .q     (ram_q)
  );

  // Captures come after the slot bookkeeping so a new access is never lost
  // to a pending flag being cleared on the same edge.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_q     <= 1'b0;
      reg_rd_q     <= 1'b0;
      dat_wr_q     <= 1'b0;
      dat_rd_q     <= 1'b0;
      d_out_active <= 1'b0;
      addr_reg     <= 8'h00;
      mode         <= 3'b000;
      phase        <= PH_PAPER;
      paper        <= '0;
      ink          <= '0;
      rd_data      <= '0;
      wr_idx       <= '0;
      wr_dat       <= '0;
      rd_idx       <= '0;
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_issued    <= 1'b0;
      rd_src       <= SRC_ADDR;
    end else begin
      reg_wr_q     <= reg_cs && wr;
      reg_rd_q     <= reg_cs && rd;
      dat_wr_q     <= dat_cs && wr;
      dat_rd_q     <= dat_cs && rd;
      d_out_active <= (reg_cs || dat_cs) && rd;
      phase        <= phase_e'(phase + 2'd1);

      case (phase)
        PH_INK: paper <= ram_q;
        PH_CPU: begin
          ink       <= ram_q;
          rd_issued <= cpu_rd;
          if (ram_we) wr_pend <= 1'b0;
        end
        PH_RDBACK: begin
          if (rd_issued) begin
            rd_data <= ram_q;
            rd_pend <= 1'b0;
          end
        end
        default: ;
      endcase

      if (reg_wr_go)
        addr_reg <= d_reg;
      else if ((pal_wr_go || pal_rd_go) && mode[MODE_AUTOINC])
        addr_reg <= addr_inc;

      if (pal_wr_go) begin
        wr_idx  <= addr_idx;
        wr_dat  <= d_reg[ENTRY_W-1:0];
        wr_pend <= 1'b1;
      end
      if (pal_rd_go) begin
        rd_idx  <= addr_idx;
        rd_pend <= 1'b1;
      end
      if (dat_wr_go && (grp == GRP_MODE))
        mode <= d_reg[2:0];

      if (reg_rd_go)
        rd_src <= SRC_ADDR;
      else if (dat_rd_go) begin
        case (grp)
          GRP_PAL:  rd_src <= SRC_PAL;
          GRP_MODE: rd_src <= SRC_MODE;
          default:  rd_src <= SRC_ZERO;
        endcase
      end
    end
  end

  always_comb begin
    d_out = 8'h00;
    case (rd_src)
      SRC_ADDR: d_out = addr_reg;
      SRC_MODE: d_out = {5'b00000, mode};
      SRC_PAL:  d_out = 8'(rd_data);
      default:  d_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_palette_unit.sv
// Bench for palette_unit: a default-size instance checked against an
// address-level palette model, plus a narrow 16x6 instance.
module tb_palette_unit;

  localparam logic [15:0] P_REG = 16'hbf3b;
  localparam logic [15:0] P_DAT = 16'hff3b;

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_w = 1'b1, en_n = 1'b0;
  logic        ioreq = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [15:0] a_reg = 16'h0000;
  logic [7:0]  d_reg = 8'h00;

  logic [7:0] d_out_w, ink_w, paper_w;
  logic       doa_w, active_w, gray_w;
  logic [5:0] ink_addr_w = 6'd0, paper_addr_w = 6'd0;

  logic [7:0] d_out_n;
  logic       doa_n, active_n, gray_n;
  logic [3:0] ink_addr_n = 4'd0, paper_addr_n = 4'd0;
  logic [5:0] ink_n, paper_n;

  int checks = 0;
  int errors = 0;

  // Reference state: what a programmer sees through the two ports.
  logic [7:0] m_pal [64];
  logic [7:0] m_addr = 8'h00;
  logic [2:0] m_mode = 3'b000;

  always #5 clk28 = ~clk28;

  palette_unit #(.ADDR_W(6), .ENTRY_W(8)) u_wide (
    .clk28(clk28), .rst_n(rst_n), .en(en_w), .ioreq(ioreq), .rd(rd), .wr(wr),
    .a_reg(a_reg), .d_reg(d_reg), .d_out(d_out_w), .d_out_active(doa_w),
    .active(active_w), .grayscale(gray_w), .ink_addr(ink_addr_w),
    .paper_addr(paper_addr_w), .ink(ink_w), .paper(paper_w)
  );

  palette_unit #(.ADDR_W(4), .ENTRY_W(6)) u_narrow (
    .clk28(clk28), .rst_n(rst_n), .en(en_n), .ioreq(ioreq), .rd(rd), .wr(wr),
    .a_reg(a_reg), .d_reg(d_reg), .d_out(d_out_n), .d_out_active(doa_n),
    .active(active_n), .grayscale(gray_n), .ink_addr(ink_addr_n),
    .paper_addr(paper_addr_n), .ink(ink_n), .paper(paper_n)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] port, input logic [7:0] data);
    @(posedge clk28); #1;
    a_reg = port; d_reg = data; ioreq = 1'b1; wr = 1'b1;
    repeat (3) @(posedge clk28);
    #1 ioreq = 1'b0; wr = 1'b0;
    repeat (3) @(posedge clk28);
  endtask

  task automatic bus_read(input logic [15:0] port, input bit nar,
                          output logic [7:0] data, output logic act);
    @(posedge clk28); #1;
    a_reg = port; ioreq = 1'b1; rd = 1'b1;
    repeat (12) @(posedge clk28);
    #1;
    data = nar ? d_out_n : d_out_w;
    act  = nar ? doa_n : doa_w;
    ioreq = 1'b0; rd = 1'b0;
    repeat (2) @(posedge clk28);
  endtask

  task automatic m_inc();
    if (m_mode[2]) m_addr[5:0] = m_addr[5:0] + 6'd1;
  endtask

  task automatic m_write(input logic [15:0] port, input logic [7:0] data);
    if (port == P_REG) m_addr = data;
    else begin
      case (m_addr[7:6])
        2'b00: begin m_pal[m_addr[5:0]] = data; m_inc(); end
        2'b01: m_mode = data[2:0];
        default: ;
      endcase
    end
  endtask

  task automatic cpu_write(input logic [15:0] port, input logic [7:0] data);
    bus_write(port, data);
    m_write(port, data);
  endtask

  task automatic cpu_read(input logic [15:0] port, input string tag);
    logic [7:0] obs, exp;
    logic act;
    bus_read(port, 1'b0, obs, act);
    if (port == P_REG) exp = m_addr;
    else begin
      case (m_addr[7:6])
        2'b00: begin exp = m_pal[m_addr[5:0]]; m_inc(); end
        2'b01: exp = {5'b00000, m_mode};
        default: exp = 8'h00;
      endcase
    end
    check(tag, obs, exp);
    check({tag, "_act"}, {7'b0, act}, 8'h01);
  endtask

  task automatic video_check(input logic [5:0] p, input logic [5:0] i, input string tag);
    @(posedge clk28); #1;
    paper_addr_w = p; ink_addr_w = i;
    repeat (9) @(posedge clk28);
    #1;
    check({tag, "_paper"}, paper_w, m_pal[p]);
    check({tag, "_ink"}, ink_w, m_pal[i]);
  endtask

  task automatic mode_check(input string tag);
    check({tag, "_active"}, {7'b0, active_w}, {7'b0, m_mode[0]});
    check({tag, "_gray"}, {7'b0, gray_w}, {7'b0, m_mode[1]});
  endtask

  initial begin
    logic [7:0] obs;
    logic act;
    int sel;

    // Reset values while held in reset
    repeat (3) @(posedge clk28);
    #1;
    check("rst_d_out", d_out_w, 8'h00);
    check("rst_doa", {7'b0, doa_w}, 8'h00);
    check("rst_active", {7'b0, active_w}, 8'h00);
    check("rst_gray", {7'b0, gray_w}, 8'h00);
    check("rst_ink", ink_w, 8'h00);
    check("rst_paper", paper_w, 8'h00);
    check("rst_paper_n", {2'b00, paper_n}, 8'h00);
    rst_n = 1'b1;

    // Mode register
    cpu_write(P_REG, 8'h40);
    cpu_write(P_DAT, 8'h03);
    mode_check("mode_wr");
    cpu_read(P_DAT, "mode_rd");

    // Fill the whole palette through auto-increment; address wraps to 0
    cpu_write(P_DAT, 8'h04);
    mode_check("mode_autoinc");
    cpu_write(P_REG, 8'h00);
    for (int k = 0; k < 64; k++) cpu_write(P_DAT, 8'($urandom));
    cpu_read(P_REG, "fill_wrap_addr");
    video_check(6'd17, 6'd42, "fill");

    // Plain write and read-back
    cpu_write(P_REG, 8'h40);
    cpu_write(P_DAT, 8'h00);
    cpu_write(P_REG, 8'h05);
    cpu_write(P_DAT, 8'hA7);
    video_check(6'd5, 6'd5, "pal5");
    cpu_read(P_DAT, "pal5_rd");

    // Auto-increment across the top of the palette
    cpu_write(P_REG, 8'h40);
    cpu_write(P_DAT, 8'h04);
    cpu_write(P_REG, 8'h3E);
    cpu_write(P_DAT, 8'h11);
    cpu_write(P_DAT, 8'h22);
    cpu_write(P_DAT, 8'h33);
    video_check(6'd62, 6'd63, "ainc_hi");
    video_check(6'd0, 6'd0, "ainc_wrap");
    cpu_read(P_REG, "ainc_addr");

    // Address rewritten right after a data capture
    cpu_write(P_REG, 8'h07);
    @(posedge clk28); #1;
    a_reg = P_DAT; d_reg = 8'h55; ioreq = 1'b1; wr = 1'b1;
    @(posedge clk28); #1;
    a_reg = P_REG; d_reg = 8'h09;
    @(posedge clk28); #1;
    ioreq = 1'b0; wr = 1'b0;
    repeat (4) @(posedge clk28);
    m_write(P_DAT, 8'h55);
    m_write(P_REG, 8'h09);
    video_check(6'd7, 6'd9, "iso");
    cpu_read(P_REG, "iso_addr");

    // Randomized mix of accesses
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: cpu_write(P_REG, {($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                             6'($urandom_range(0, 63))});
        1, 2: cpu_write(P_DAT, 8'($urandom));
        3: cpu_read(P_DAT, "rnd_dat_rd");
        4: video_check(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "rnd_vid");
        default: begin
          cpu_write(P_REG, 8'h40);
          cpu_write(P_DAT, 8'($urandom_range(0, 7)));
          mode_check("rnd_mode");
          cpu_read(P_REG, "rnd_addr");
          cpu_write(P_REG, {2'b00, 6'($urandom_range(0, 63))});
        end
      endcase
    end

    // Reset between capture and the CPU slot drops the write
    cpu_write(P_REG, 8'h40);
    cpu_write(P_DAT, 8'h00);
    cpu_write(P_REG, 8'h0C);
    @(posedge clk28); #1;
    a_reg = P_DAT; d_reg = 8'h5A ^ m_pal[12]; ioreq = 1'b1; wr = 1'b1;
    @(posedge clk28); #1;
    rst_n = 1'b0; ioreq = 1'b0; wr = 1'b0;
    #1;
    check("midrst_ink", ink_w, 8'h00);
    check("midrst_paper", paper_w, 8'h00);
    check("midrst_doa", {7'b0, doa_w}, 8'h00);
    check("midrst_d_out", d_out_w, 8'h00);
    repeat (2) @(posedge clk28);
    #1 rst_n = 1'b1;
    m_addr = 8'h00;
    m_mode = 3'b000;
    mode_check("midrst_mode");
    video_check(6'd12, 6'd12, "midrst");
    cpu_read(P_REG, "midrst_addr");

    // Port decode disabled
    en_w = 1'b0;
    bus_write(P_REG, 8'h2A);
    bus_write(P_DAT, 8'h99 ^ m_pal[0]);
    bus_read(P_REG, 1'b0, obs, act);
    check("gate_doa", {7'b0, act}, 8'h00);
    en_w = 1'b1;
    cpu_read(P_REG, "gate_addr");
    video_check(6'd0, 6'd0, "gate");

    // Narrow instance: 16 entries of 6 bits
    en_w = 1'b0;
    en_n = 1'b1;
    bus_write(P_REG, 8'h12);
    bus_write(P_DAT, 8'hFF);
    @(posedge clk28); #1;
    paper_addr_n = 4'd2; ink_addr_n = 4'd2;
    repeat (9) @(posedge clk28);
    #1;
    check("nar_paper", {2'b00, paper_n}, 8'h3F);
    check("nar_ink", {2'b00, ink_n}, 8'h3F);
    bus_read(P_DAT, 1'b1, obs, act);
    check("nar_rd", obs, 8'h3F);
    check("nar_rd_act", {7'b0, act}, 8'h01);
    bus_read(P_REG, 1'b1, obs, act);
    check("nar_addr", obs, 8'h12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/palette_unit.md
# palette_unit

Parametrised ULAplus-compatible palette controller. Replaces the fixed 64×8 palette block and sits between the CPU I/O bus and the screen pixel pipeline. Adds palette read-back, address auto-increment, a grayscale mode flag and configurable palette depth and entry width. A single synchronous palette RAM is time-shared between video (ink, paper) and CPU slots on a 4-phase rotation.

## Interface
- `ADDR_W`, 6: palette index width, 1..6; the palette has 2^ADDR_W entries.
- `ENTRY_W`, 8: palette entry width, 1..8.
- `clk28`  in  1  system clock, 28 MHz.
- `rst_n`  in  1  reset; asynchronous assert and release, active-low.
- `en`  in  1  enables port decode; when low, all port accesses are ignored.
- `bus`  cpu_bus  -  uses `ioreq`, `rd`, `wr`, `a_reg[15:0]`, `d_reg[7:0]`.
- `d_out`  out  8  read data to the bus mux.
- `d_out_active`  out  1  asserts that `d_out` must be driven onto the bus.
- `active`  out  1  ULAplus palette enabled (mode bit 0).
- `grayscale`  out  1  entries are luminance values (mode bit 1).
- `ink_addr`  in  ADDR_W  palette index for ink.
- `paper_addr`  in  ADDR_W  palette index for paper.
- `ink`  out  ENTRY_W  ink colour.
- `paper`  out  ENTRY_W  paper colour.

## Operation
- **Ports.**
  - `reg_cs = en && ioreq && a_reg == 16'hbf3b`.
  - `dat_cs = en && ioreq && a_reg == 16'hff3b`.
- **Edge detection.** `wr`/`rd` accesses are acted on once per access, on the first clk28 cycle in which cs&&wr or cs&&rd is true (rising edge of the registered condition).
- **bf3b write.** `addr_reg <= d_reg`. `addr_reg[7:6]` is the group: 00 palette, 01 mode, 10/11 reserved.
- **bf3b read.** Returns `addr_reg`.
- **ff3b write, group 00.**
  - Capture `wr_idx = addr_reg[ADDR_W-1:0]` and `wr_dat = d_reg[ENTRY_W-1:0]`.
  - Set `wr_pend`.
- **ff3b read, group 00.** Capture `rd_idx`, set `rd_pend`.
- **Palette data returned.** `d_out` is the entry zero-extended to 8 bits.
- **ff3b write, group 01.** `mode <= d_reg[2:0]`.
  - bit0 = active.
  - bit1 = grayscale.
  - bit2 = autoinc.
- **ff3b read, group 01.** Returns `{5'b0, mode}`.
- **Reserved groups.** Writes are ignored; reads return 8'h00.
- **Auto-increment.** When autoinc = 1, every ff3b group-00 access increments `addr_reg[5:0]` in the capture cycle. It wraps modulo 2^ADDR_W, and bits [7:6] are unchanged.
- **Capture isolation.** A bf3b write in the same cycle as, or after, a capture does not affect the pending access, which uses the captured index.
- **Slot counter.** `phase[1:0]` increments every clk28.
  - Phase 0: RAM address = `paper_addr`.
  - Phase 1: RAM address = `ink_addr`; latch RAM q into `paper`.
  - Phase 2: CPU slot.
    - If `wr_pend`: write `wr_dat` at `wr_idx` and clear `wr_pend`.
    - Else if `rd_pend`: address = `rd_idx`.
    - Latch RAM q into `ink`.
  - Phase 3: if a read was issued in phase 2, latch RAM q into `rd_data` and clear `rd_pend`.
- **Write/read priority.** A write beats a read in the same slot; the read waits one rotation.
- **Read-after-write.** Read-after-write of the same index returns the new value.
- **d_out source.**
  - For ff3b group 00: `rd_data`.
  - Otherwise: the combinational group/addr value.
  - Selected by the registered port/group of the last read.
- **d_out_active.** Registered `(reg_cs||dat_cs) && rd`.

## Timing
- **Reset values.**
  - `addr_reg` = 0, `mode` = 0, `active` = 0, `grayscale` = 0.
  - `ink` = 0, `paper` = 0, `rd_data` = 0.
  - `wr_pend` = 0, `rd_pend` = 0, `phase` = 0.
  - `d_out_active` = 0.
  - Palette RAM contents are not reset.
- **Reset mid-access.** Pending accesses are dropped.
- **Video latency.**
  - `paper` reflects `paper_addr` sampled at phase 0, updated 1 cycle later.
  - `ink` reflects `ink_addr` sampled at phase 1, updated 1 cycle later.
  - Each output refreshes every 4 cycles (7 MHz).
- **CPU write.** Lands in RAM at most 4 cycles after the capture edge.
- **CPU read.** `rd_data` is valid at most 5 cycles after the capture edge, or at most 9 cycles if a write is pending. Both are well inside a Z80 I/O cycle (≥ 28 clk28).
- **Mode/addr register updates.** Take effect the cycle after the capture edge.

## Structure
- **Package `ulaplus_pkg`.**
  - Port constants `PORT_REG = 16'hbf3b`, `PORT_DAT = 16'hff3b`.
  - Group enum `GRP_PAL=2'b00`, `GRP_MODE=2'b01`.
  - Mode bit indices `MODE_ACTIVE=0`, `MODE_GRAY=1`, `MODE_AUTOINC=2`.
- **Sub-module `palette_ram`.** Parameters `AW`, `DW`; single-port synchronous RAM with write-first-free read: q registered from `mem[a]` each cycle, write when `we`.

## Test plan
- **Mode write.** bf3b←0x40, ff3b←0x03 → `active`=1, `grayscale`=1. ff3b read → d_out=0x03 with `d_out_active` high.
- **Palette write/read-back.** bf3b←0x05, ff3b←0xA7; drive `paper_addr`=5 → `paper`=0xA7 within 8 cycles. ff3b read → 0xA7.
- **Auto-increment.** Mode←0x04, bf3b←0x3E; write 0x11, 0x22, 0x33 → entries 62=0x11, 63=0x22, 0=0x33; bf3b read → 0x01.
- **Capture isolation.** ff3b←0x55 with idx 7, immediately followed by bf3b←0x09 → entry 7=0x55, entry 9 unchanged.
- **Narrow configuration.** `ADDR_W`=4, `ENTRY_W`=6: write 0xFF at bf3b 0x12 → entry 2=0x3F; read → 0x3F.
- **Reset and gating.** Assert `rst_n` low between capture and phase 2 → no RAM write, all outputs at reset values. With `en`=0, bf3b/ff3b writes are ignored.
